// File: rtl/mult_disp_pkg.sv
// Shared types, widths and segment patterns for the multiplier display controller.
package mult_disp_pkg;

  localparam int unsigned OPW       = 4;
  localparam int unsigned PRODW     = 8;
  localparam int unsigned NDIG      = 3;
  localparam int unsigned MUL_ITERS = 4;
  localparam int unsigned BCD_ITERS = 8;
  localparam int unsigned BCDW      = 4 * NDIG;
  localparam int unsigned DABW      = BCDW + PRODW;
  localparam int unsigned CNTW      = $clog2(BCD_ITERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    BCD  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // One double-dabble iteration: correct every BCD nibble >= 5, then shift left.
  function automatic logic [DABW-1:0] dabble_step(input logic [DABW-1:0] d);
    logic [DABW-1:0] w;
    w = d;
    for (int unsigned i = 0; i < NDIG; i++) begin
      if (w[PRODW + 4*i +: 4] >= 4'd5)
        w[PRODW + 4*i +: 4] = w[PRODW + 4*i +: 4] + 4'd3;
    end
    return {w[DABW-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high 7-segment pattern decoder.
module bcd_to_seg7
  import mult_disp_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg_c
);

  always_comb begin
    o_seg_c = SEG_BLANK;
    case (i_nibble)
      4'd0:    o_seg_c = SEG_0;
      4'd1:    o_seg_c = SEG_1;
      4'd2:    o_seg_c = SEG_2;
      4'd3:    o_seg_c = SEG_3;
      4'd4:    o_seg_c = SEG_4;
      4'd5:    o_seg_c = SEG_5;
      4'd6:    o_seg_c = SEG_6;
      4'd7:    o_seg_c = SEG_7;
      4'd8:    o_seg_c = SEG_8;
      4'd9:    o_seg_c = SEG_9;
      default: o_seg_c = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/mult_disp_ctrl.sv
// Shift-add 4x4 multiplier with double-dabble BCD conversion and a scanned
// three-digit 7-segment display of the last completed product.
module mult_disp_ctrl
  import mult_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OPW-1:0]   a,
  input  logic [OPW-1:0]   b,
  output logic             busy,
  output logic             out_valid,
  output logic [PRODW-1:0] product,
  output logic [BCDW-1:0]  bcd,
  output logic [6:0]       seg,
  output logic [NDIG-1:0]  dig_en
);

  localparam int unsigned SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PRODW-1:0] r_a_sh;
  logic [OPW-1:0]   r_b;
  logic [PRODW-1:0] r_acc;
  logic [PRODW-1:0] w_acc_nxt;
  logic [CNTW-1:0]  r_cnt;
  logic [DABW-1:0]  r_dab;
  logic [DABW-1:0]  w_dab_nxt;
  logic             w_accept;
  logic             w_mul_last;
  logic             w_bcd_last;

  logic             r_in_ready;
  logic             r_busy;
  logic             r_out_valid;
  logic [PRODW-1:0] r_product;
  logic [BCDW-1:0]  r_bcd;
  logic [6:0]       r_seg;
  logic [NDIG-1:0]  r_dig_en;
  logic [SCW-1:0]   r_scan;
  logic             w_scan_wrap;
  logic [NDIG-1:0]  w_dig_nxt;
  logic [3:0]       w_nibble;
  logic [6:0]       w_seg_c;

  assign w_accept   = in_valid && r_in_ready;
  assign w_mul_last = (r_cnt == CNTW'(MUL_ITERS - 1));
  assign w_bcd_last = (r_cnt == CNTW'(BCD_ITERS - 1));
  assign w_acc_nxt  = r_b[0] ? (r_acc + r_a_sh) : r_acc;
  assign w_dab_nxt  = dabble_step(r_dab);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept)   w_state_nxt = MUL;
      MUL:     if (w_mul_last) w_state_nxt = BCD;
      BCD:     if (w_bcd_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Datapath and registered handshake/result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh      <= '0;
      r_b         <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_dab       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_product   <= '0;
      r_bcd       <= '0;
    end else begin
      r_in_ready  <= (w_state_nxt == IDLE);
      r_busy      <= (w_state_nxt != IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a_sh <= PRODW'(a);
            r_b    <= b;
            r_acc  <= '0;
            r_cnt  <= '0;
          end
        end
        MUL: begin
          r_acc  <= w_acc_nxt;
          r_a_sh <= {r_a_sh[PRODW-2:0], 1'b0};
          r_b    <= {1'b0, r_b[OPW-1:1]};
          if (w_mul_last) begin
            r_cnt <= '0;
            r_dab <= {BCDW'(0), w_acc_nxt};
          end else begin
            r_cnt <= r_cnt + CNTW'(1);
          end
        end
        BCD: begin
          r_dab <= w_dab_nxt;
          r_cnt <= r_cnt + CNTW'(1);
          // Result registers load on the edge into DONE so they are valid with out_valid.
          if (w_bcd_last) begin
            r_product <= r_acc;
            r_bcd     <= w_dab_nxt[DABW-1:PRODW];
          end
        end
        default: ;
      endcase
    end
  end

  assign w_scan_wrap = (r_scan == SCW'(SCAN_DIV - 1));
  assign w_dig_nxt   = w_scan_wrap ? {r_dig_en[NDIG-2:0], r_dig_en[NDIG-1]} : r_dig_en;

  // Nibble for the digit enabled after this edge, taken from the currently held bcd
  always_comb begin
    w_nibble = r_bcd[3:0];
    case (w_dig_nxt)
      3'b010:  w_nibble = r_bcd[7:4];
      3'b100:  w_nibble = r_bcd[11:8];
      default: w_nibble = r_bcd[3:0];
    endcase
  end

  bcd_to_seg7 u_seg_dec (
    .i_nibble (w_nibble),
    .o_seg_c  (w_seg_c)
  );

  // Free-running scan, independent of the FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan   <= '0;
      r_dig_en <= 3'b001;
      r_seg    <= SEG_0;
    end else begin
      r_scan   <= w_scan_wrap ? '0 : r_scan + SCW'(1);
      r_dig_en <= w_dig_nxt;
      r_seg    <= w_seg_c;
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign product   = r_product;
  assign bcd       = r_bcd;
  assign seg       = r_seg;
  assign dig_en    = r_dig_en;

endmodule
